// File: rtl/rs422_pkg.sv
// Shared types and constants for the RS422 frame-echo controller.
package rs422_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RECV,
      ST_LOAD,
      ST_STROBE,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } state_t;

   localparam logic [1:0] MODE_ECHO    = 2'd0;
   localparam logic [1:0] MODE_REV     = 2'd1;
   localparam logic [1:0] MODE_LEN     = 2'd2;
   localparam logic [1:0] MODE_DISCARD = 2'd3;

   // Three characters of silence at 16x oversampling.
   localparam int GAP_TICKS_DEF = 480;

endpackage

// File: rtl/rs422_frame_ram.sv
// Frame buffer: simple dual-port RAM, synchronous write, registered 1-cycle read.
module rs422_frame_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/rs422_frame_echo.sv
// Collects UART bytes into a frame closed by a quiet gap, then replays it
// as echo, reversed, length-prefixed, or discards it.
//
// state        | meaning
// ST_IDLE      | waiting for the first byte of a frame
// ST_RECV      | storing bytes, gap timer running
// ST_LOAD      | read address presented to the buffer
// ST_STROBE    | character registered into tx_data, tx_en pulsed
// ST_WAIT_BUSY | waiting for the transmitter to accept (tx_idle low)
// ST_WAIT_DONE | waiting for the transmitter to finish (tx_idle high)
module rs422_frame_echo
   import rs422_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 64,
   parameter int GAP_TICKS = GAP_TICKS_DEF,
   localparam int ADDR_W   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              tx_idle,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_en,
   output logic              busy,
   output logic [ADDR_W:0]   frame_len,
   output logic              overflow,
   output logic [7:0]        drop_cnt
);

   localparam int GW = $clog2(GAP_TICKS + 1);
   localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_TICKS - 1);
   localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);

   state_t            state;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   remaining;
   logic [GW-1:0]     gap;
   logic [1:0]        mode_q;
   logic              hdr;
   logic [ADDR_W-1:0] rd_ptr;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              in_tx;

   assign in_tx   = (state != ST_IDLE) && (state != ST_RECV);
   assign wr_en   = rx_valid && ((state == ST_IDLE) ||
                                 ((state == ST_RECV) && (count < DEPTH_C)));
   assign wr_addr = (state == ST_IDLE) ? '0 : count[ADDR_W-1:0];
   // The header character comes from frame_len, so no buffer read for it.
   assign rd_en   = (state == ST_LOAD) && !hdr;

   rs422_frame_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (rx_data),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         count     <= '0;
         remaining <= '0;
         gap       <= '0;
         mode_q    <= MODE_ECHO;
         hdr       <= 1'b0;
         rd_ptr    <= '0;
         tx_data   <= '0;
         tx_en     <= 1'b0;
         busy      <= 1'b0;
         frame_len <= '0;
         overflow  <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         tx_en <= 1'b0;
         if (rx_valid && in_tx && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 1'b1;

         case (state)
            ST_IDLE: begin
               if (rx_valid) begin
                  count    <= (ADDR_W + 1)'(1);
                  overflow <= 1'b0;
                  mode_q   <= mode;
                  gap      <= GAP_LAST;
                  busy     <= 1'b1;
                  state    <= ST_RECV;
               end
            end

            ST_RECV: begin
               if (rx_valid) begin
                  gap <= GAP_LAST;
                  if (count < DEPTH_C) count <= count + 1'b1;
                  else                 overflow <= 1'b1;
               end else if (gap == '0) begin
                  frame_len <= count;
                  remaining <= count;
                  hdr       <= 1'b0;
                  rd_ptr    <= '0;
                  case (mode_q)
                     MODE_ECHO: state <= ST_LOAD;
                     MODE_REV: begin
                        rd_ptr <= ADDR_W'(count - 1'b1);
                        state  <= ST_LOAD;
                     end
                     MODE_LEN: begin
                        hdr   <= 1'b1;
                        state <= ST_LOAD;
                     end
                     default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                     end
                  endcase
               end else begin
                  gap <= gap - 1'b1;
               end
            end

            ST_LOAD: state <= ST_STROBE;

            ST_STROBE: begin
               tx_en <= 1'b1;
               if (hdr) begin
                  tx_data <= DATA_W'(frame_len);
                  hdr     <= 1'b0;
               end else begin
                  tx_data   <= rd_data;
                  remaining <= remaining - 1'b1;
                  rd_ptr    <= (mode_q == MODE_REV) ? rd_ptr - 1'b1 : rd_ptr + 1'b1;
               end
               state <= ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
               if (!tx_idle) state <= ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
               if (tx_idle) begin
                  if (remaining != '0) begin
                     state <= ST_LOAD;
                  end else begin
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rs422_frame_echo.sv
// Directed bench for rs422_frame_echo with a transmitter model and byte scoreboard.
module tb_rs422_frame_echo;
   import rs422_pkg::*;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 64;
   localparam int GAP    = 480;
   localparam int TX_LEN = 6;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] mode;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_idle;
   logic [7:0] tx_data;
   logic       tx_en;
   logic       busy;
   logic [6:0] frame_len;
   logic       overflow;
   logic [7:0] drop_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int viol  = 0;
   int tx_left = 0;
   int found;
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];

   rs422_frame_echo #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .GAP_TICKS (GAP)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .mode      (mode),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_idle   (tx_idle),
      .tx_data   (tx_data),
      .tx_en     (tx_en),
      .busy      (busy),
      .frame_len (frame_len),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   // Transmitter model: goes busy for TX_LEN cycles after each tx_en.
   initial begin
      tx_idle = 1'b1;
      forever begin
         @(negedge clk);
         if (tx_en) begin
            obs_q.push_back(tx_data);
            if (!tx_idle) viol++;
            tx_idle = 1'b0;
            tx_left = TX_LEN;
         end else if (tx_left > 0) begin
            tx_left--;
            if (tx_left == 0) tx_idle = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic rx_byte(input logic [7:0] b, input int quiet);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      if (quiet > 0) begin
         repeat (quiet) @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check({tag, "_idle"}, 32'(busy), 32'h0);
      @(posedge clk); #1;
   endtask

   task automatic compare_frame(input string tag);
      check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && obs_q.size() > 0)
         check({tag, "_data"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_tx_en"},     32'(tx_en),     32'h0);
      check({tag, "_tx_data"},   32'(tx_data),   32'h0);
      check({tag, "_busy"},      32'(busy),      32'h0);
      check({tag, "_frame_len"}, 32'(frame_len), 32'h0);
      check({tag, "_overflow"},  32'(overflow),  32'h0);
      check({tag, "_drop_cnt"},  32'(drop_cnt),  32'h0);
   endtask

   initial begin
      reset_n  = 1'b1;
      mode     = MODE_ECHO;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1 check_reset_values("reset");
      #20 reset_n = 1'b1;
      @(posedge clk); #1;

      // Plain echo
      mode = MODE_ECHO;
      rx_byte(8'h41, 2); rx_byte(8'h42, 2); rx_byte(8'h43, 0);
      exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
      wait_idle("echo");
      compare_frame("echo");
      check("echo_frame_len", 32'(frame_len), 32'd3);
      check("echo_busy", 32'(busy), 32'h0);

      // Reverse
      mode = MODE_REV;
      for (int i = 1; i <= 5; i++) rx_byte(8'(i), 2);
      for (int i = 5; i >= 1; i--) exp_q.push_back(8'(i));
      wait_idle("rev");
      compare_frame("rev");
      check("rev_frame_len", 32'(frame_len), 32'd5);

      // Length header; mode changes after the first byte must be ignored
      mode = MODE_LEN;
      rx_byte(8'h10, 2);
      mode = MODE_DISCARD;
      rx_byte(8'h20, 0);
      exp_q.push_back(8'h02); exp_q.push_back(8'h10); exp_q.push_back(8'h20);
      wait_idle("hdr");
      compare_frame("hdr");
      check("hdr_frame_len", 32'(frame_len), 32'd2);

      // Overflow: 70 bytes, only the first 64 kept
      mode = MODE_ECHO;
      for (int i = 0; i < 70; i++) begin
         rx_byte(8'(i), 1);
         if (i < DEPTH) exp_q.push_back(8'(i));
      end
      wait_idle("ovf");
      compare_frame("ovf");
      check("ovf_flag", 32'(overflow), 32'h1);
      check("ovf_frame_len", 32'(frame_len), 32'd64);
      rx_byte(8'h77, 0);
      check("ovf_clear", 32'(overflow), 32'h0);
      exp_q.push_back(8'h77);
      wait_idle("ovf_next");
      compare_frame("ovf_next");
      check("ovf_next_frame_len", 32'(frame_len), 32'd1);

      // Bytes arriving while the transmitter is busy are dropped
      mode = MODE_ECHO;
      rx_byte(8'hAA, 2); rx_byte(8'hBB, 2); rx_byte(8'hCC, 0);
      exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC);
      found = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!tx_idle) begin found = 1; break; end
      end
      check("drop_wait", 32'(found), 32'h1);
      @(posedge clk); #1;
      rx_data  = 8'hEE;
      rx_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 rx_valid = 1'b0;
      wait_idle("drop");
      compare_frame("drop");
      check("drop_cnt", 32'(drop_cnt), 32'd3);
      check("drop_busy", 32'(busy), 32'h0);

      // A byte at gap count GAP-1 extends the frame
      mode = MODE_ECHO;
      rx_byte(8'h51, GAP - 1);
      rx_byte(8'h52, 0);
      exp_q.push_back(8'h51); exp_q.push_back(8'h52);
      wait_idle("gap");
      compare_frame("gap");
      check("gap_frame_len", 32'(frame_len), 32'd2);

      // Discard mode: no transmission, frame_len still updates
      mode = MODE_DISCARD;
      rx_byte(8'h61, 2); rx_byte(8'h62, 2); rx_byte(8'h63, 2); rx_byte(8'h64, 0);
      wait_idle("discard");
      compare_frame("discard");
      check("discard_frame_len", 32'(frame_len), 32'd4);

      // Reset while waiting for the transmitter to accept
      mode = MODE_ECHO;
      rx_byte(8'h71, 2); rx_byte(8'h72, 0);
      found = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (tx_en) begin found = 1; break; end
      end
      check("rst_wait", 32'(found), 32'h1);
      #1 reset_n = 1'b0;
      #1 check_reset_values("midrst");
      exp_q.delete();
      obs_q.delete();
      #2 reset_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_idle) break;
      end
      @(posedge clk); #1;
      rx_byte(8'h7A, 2); rx_byte(8'h7B, 0);
      exp_q.push_back(8'h7A); exp_q.push_back(8'h7B);
      wait_idle("after_rst");
      compare_frame("after_rst");
      check("after_rst_frame_len", 32'(frame_len), 32'd2);

      check("tx_en_while_busy", 32'(viol), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
